// File: rtl/ok_bridge_pkg.sv
// Shared types and default widths for the Opal Kelly wire <-> valid/ready stream bridge.
package ok_bridge_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {IN_IDLE, IN_VALID} in_state_e;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // Which side of the holding register produces the beat.
  typedef enum logic {DIR_TGL_TO_VR, DIR_VR_TO_TGL} hold_dir_e;

endpackage

// File: rtl/toggle_hold_reg.sv
// One-entry holding register bridging a toggle handshake and a valid/ready handshake.
// DIR_TGL_TO_VR: tgl_in=request, tgl_out=ack, hs_in=ready, hs_out=valid.
// DIR_VR_TO_TGL: tgl_in=host ack, tgl_out=avail, hs_in=valid, hs_out=ready.
module toggle_hold_reg
  import ok_bridge_pkg::*;
#(
  parameter int        W   = 32,
  parameter hold_dir_e DIR = DIR_TGL_TO_VR
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tgl_in,
  output logic         tgl_out,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  input  logic         hs_in,
  output logic         hs_out,
  output logic         fire
);

  assign fire = hs_out & hs_in;

  generate
    if (DIR == DIR_TGL_TO_VR) begin : g_tgl_to_vr
      in_state_e state;
      logic      req_seen;

      always_ff @(posedge clock) begin
        if (reset) begin
          state    <= IN_IDLE;
          req_seen <= 1'b0;
          tgl_out  <= 1'b0;
          data_out <= '0;
          hs_out   <= 1'b0;
        end else begin
          case (state)
            IN_IDLE: begin
              if (tgl_in != req_seen) begin
                data_out <= data_in;
                req_seen <= tgl_in;
                hs_out   <= 1'b1;
                state    <= IN_VALID;
              end
            end
            // Toggle changes are deliberately ignored here; there is no queue.
            IN_VALID: begin
              if (hs_in) begin
                hs_out  <= 1'b0;
                tgl_out <= req_seen;
                state   <= IN_IDLE;
              end
            end
            default: state <= IN_IDLE;
          endcase
        end
      end
    end else begin : g_vr_to_tgl
      out_state_e state;

      always_ff @(posedge clock) begin
        if (reset) begin
          state    <= OUT_EMPTY;
          tgl_out  <= 1'b0;
          data_out <= '0;
          hs_out   <= 1'b0;
        end else begin
          case (state)
            // Ready is registered, so it drops the cycle after a fire and cannot double-capture.
            OUT_EMPTY: begin
              if (hs_out && hs_in) begin
                data_out <= data_in;
                tgl_out  <= ~tgl_out;
                hs_out   <= 1'b0;
                state    <= OUT_FULL;
              end else begin
                hs_out <= 1'b1;
              end
            end
            OUT_FULL: begin
              hs_out <= 1'b0;
              if (tgl_in == tgl_out) begin
                state <= OUT_EMPTY;
              end
            end
            default: state <= OUT_EMPTY;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ok_wire_stream_bridge.sv
// Host-side bridge between polled Opal Kelly wire endpoints and the DUT valid/ready host streams.
module ok_wire_stream_bridge
  import ok_bridge_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             host_in_req_tgl,
  input  logic [IN_W-1:0]  host_in_data,
  output logic             host_in_ack_tgl,
  output logic             in_valid,
  input  logic             in_ready,
  output logic [IN_W-1:0]  in_bits,
  input  logic             out_valid,
  output logic             out_ready,
  input  logic [OUT_W-1:0] out_bits,
  output logic             host_out_avail_tgl,
  output logic [OUT_W-1:0] host_out_data,
  input  logic             host_out_ack_tgl,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count
);

  logic in_fire;
  logic out_fire;

  toggle_hold_reg #(
    .W   (IN_W),
    .DIR (DIR_TGL_TO_VR)
  ) u_in_hold (
    .clock    (clock),
    .reset    (reset),
    .tgl_in   (host_in_req_tgl),
    .tgl_out  (host_in_ack_tgl),
    .data_in  (host_in_data),
    .data_out (in_bits),
    .hs_in    (in_ready),
    .hs_out   (in_valid),
    .fire     (in_fire)
  );

  toggle_hold_reg #(
    .W   (OUT_W),
    .DIR (DIR_VR_TO_TGL)
  ) u_out_hold (
    .clock    (clock),
    .reset    (reset),
    .tgl_in   (host_out_ack_tgl),
    .tgl_out  (host_out_avail_tgl),
    .data_in  (out_bits),
    .data_out (host_out_data),
    .hs_in    (out_valid),
    .hs_out   (out_ready),
    .fire     (out_fire)
  );

  // Debug beat counters wrap freely.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (in_fire)  in_count  <= in_count + CNT_W'(1);
      if (out_fire) out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ok_wire_stream_bridge.sv
// Directed self-checking bench for ok_wire_stream_bridge (CNT_W=4 so wrap is reachable).
module tb_ok_wire_stream_bridge;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             host_in_req_tgl = 1'b0;
  logic [IN_W-1:0]  host_in_data = '0;
  logic             host_in_ack_tgl;
  logic             in_valid;
  logic             in_ready = 1'b0;
  logic [IN_W-1:0]  in_bits;
  logic             out_valid = 1'b0;
  logic             out_ready;
  logic [OUT_W-1:0] out_bits = '0;
  logic             host_out_avail_tgl;
  logic [OUT_W-1:0] host_out_data;
  logic             host_out_ack_tgl = 1'b0;
  logic [CNT_W-1:0] in_count;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  ok_wire_stream_bridge #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .host_in_req_tgl    (host_in_req_tgl),
    .host_in_data       (host_in_data),
    .host_in_ack_tgl    (host_in_ack_tgl),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_bits            (in_bits),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_bits           (out_bits),
    .host_out_avail_tgl (host_out_avail_tgl),
    .host_out_data      (host_out_data),
    .host_out_ack_tgl   (host_out_ack_tgl),
    .in_count           (in_count),
    .out_count          (out_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (in_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_valid got %0h want 0", in_valid); end
    checks++; if (in_bits !== 32'h0) begin errors++; $display("[TB] FAIL reset_in_bits got %0h want 0", in_bits); end
    checks++; if (host_in_ack_tgl !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ack got %0h want 0", host_in_ack_tgl); end
    checks++; if (out_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ready got %0h want 0", out_ready); end
    checks++; if (host_out_avail_tgl !== 1'b0) begin errors++; $display("[TB] FAIL reset_avail got %0h want 0", host_out_avail_tgl); end
    checks++; if (host_out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_data got %0h want 0", host_out_data); end
    checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", in_count, out_count); end
    reset = 1'b0;
    tick();
    checks++; if (out_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_out_ready got %0h want 1", out_ready); end
  endtask

  task automatic test_single_in();
    host_in_data    = 32'hBEEF_0001;
    in_ready        = 1'b1;
    host_in_req_tgl = 1'b1;
    tick();
    checks++; if (in_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0h want 1", in_valid); end
    checks++; if (in_bits !== 32'hBEEF_0001) begin errors++; $display("[TB] FAIL single_bits got %0h want beef0001", in_bits); end
    checks++; if (host_in_ack_tgl !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_early got %0h want 0", host_in_ack_tgl); end
    tick();
    checks++; if (in_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_drop got %0h want 0", in_valid); end
    checks++; if (host_in_ack_tgl !== 1'b1) begin errors++; $display("[TB] FAIL single_ack got %0h want 1", host_in_ack_tgl); end
    checks++; if (in_count !== 4'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", in_count); end
  endtask

  task automatic test_in_backpressure();
    in_ready        = 1'b0;
    host_in_data    = 32'h0000_0002;
    host_in_req_tgl = 1'b0;
    tick();
    host_in_data = 32'hDEAD_DEAD;
    for (int i = 0; i < 10; i++) begin
      checks++; if (in_valid !== 1'b1 || in_bits !== 32'h0000_0002) begin errors++; $display("[TB] FAIL bp_hold cycle %0d got %0h/%0h want 1/00000002", i, in_valid, in_bits); end
      tick();
    end
    checks++; if (host_in_ack_tgl !== 1'b1 || in_count !== 4'd1) begin errors++; $display("[TB] FAIL bp_no_fire got ack %0h cnt %0d want 1/1", host_in_ack_tgl, in_count); end
    in_ready = 1'b1;
    tick();
    checks++; if (in_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop got %0h want 0", in_valid); end
    checks++; if (host_in_ack_tgl !== 1'b0) begin errors++; $display("[TB] FAIL bp_ack got %0h want 0", host_in_ack_tgl); end
    checks++; if (in_count !== 4'd2) begin errors++; $display("[TB] FAIL bp_count got %0d want 2", in_count); end
    tick();
    checks++; if (in_valid !== 1'b0 || in_count !== 4'd2) begin errors++; $display("[TB] FAIL bp_single_fire got %0h/%0d want 0/2", in_valid, in_count); end
  endtask

  task automatic test_out_hold();
    out_valid = 1'b1;
    out_bits  = 16'h00A5;
    tick();
    checks++; if (host_out_avail_tgl !== 1'b1) begin errors++; $display("[TB] FAIL out_avail got %0h want 1", host_out_avail_tgl); end
    checks++; if (host_out_data !== 16'h00A5) begin errors++; $display("[TB] FAIL out_data got %0h want 00a5", host_out_data); end
    checks++; if (out_ready !== 1'b0) begin errors++; $display("[TB] FAIL out_ready_drop got %0h want 0", out_ready); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("[TB] FAIL out_count1 got %0d want 1", out_count); end
    out_bits = 16'h00B6;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (out_count !== 4'd1 || out_ready !== 1'b0 || host_out_data !== 16'h00A5) begin errors++; $display("[TB] FAIL out_hold cycle %0d got cnt %0d rdy %0h data %0h want 1/0/00a5", i, out_count, out_ready, host_out_data); end
    end
    host_out_ack_tgl = 1'b1;
    tick();
    checks++; if (out_ready !== 1'b0) begin errors++; $display("[TB] FAIL out_ready_reg got %0h want 0", out_ready); end
    tick();
    checks++; if (out_ready !== 1'b1 || out_count !== 4'd1) begin errors++; $display("[TB] FAIL out_ready_back got %0h/%0d want 1/1", out_ready, out_count); end
    tick();
    checks++; if (out_count !== 4'd2 || host_out_avail_tgl !== 1'b0 || host_out_data !== 16'h00B6) begin errors++; $display("[TB] FAIL out_second got cnt %0d avail %0h data %0h want 2/0/00b6", out_count, host_out_avail_tgl, host_out_data); end
    out_valid        = 1'b0;
    host_out_ack_tgl = 1'b0;
    tick();
    tick();
    checks++; if (out_ready !== 1'b1 || out_count !== 4'd2) begin errors++; $display("[TB] FAIL out_idle got %0h/%0d want 1/2", out_ready, out_count); end
  endtask

  task automatic test_simultaneous();
    host_in_data    = 32'hCAFE_0003;
    in_ready        = 1'b1;
    host_in_req_tgl = 1'b1;
    tick();
    checks++; if (in_valid !== 1'b1 || out_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_setup got %0h/%0h want 1/1", in_valid, out_ready); end
    out_valid = 1'b1;
    out_bits  = 16'h1234;
    tick();
    checks++; if (in_count !== 4'd3 || out_count !== 4'd3) begin errors++; $display("[TB] FAIL sim_counts got %0d/%0d want 3/3", in_count, out_count); end
    checks++; if (host_in_ack_tgl !== 1'b1 || host_out_avail_tgl !== 1'b1) begin errors++; $display("[TB] FAIL sim_toggles got %0h/%0h want 1/1", host_in_ack_tgl, host_out_avail_tgl); end
    checks++; if (host_out_data !== 16'h1234 || in_valid !== 1'b0 || out_ready !== 1'b0) begin errors++; $display("[TB] FAIL sim_state got data %0h v %0h r %0h want 1234/0/0", host_out_data, in_valid, out_ready); end
  endtask

  task automatic test_reset_mid();
    in_ready        = 1'b0;
    host_in_data    = 32'h1111_2222;
    host_in_req_tgl = 1'b0;
    tick();
    checks++; if (in_valid !== 1'b1 || host_out_avail_tgl !== 1'b1) begin errors++; $display("[TB] FAIL mid_setup got %0h/%0h want 1/1", in_valid, host_out_avail_tgl); end
    reset            = 1'b1;
    host_in_req_tgl  = 1'b0;
    host_out_ack_tgl = 1'b0;
    tick();
    checks++; if (in_valid !== 1'b0 || in_bits !== 32'h0 || host_in_ack_tgl !== 1'b0) begin errors++; $display("[TB] FAIL mid_in_reset got %0h/%0h/%0h want 0/0/0", in_valid, in_bits, host_in_ack_tgl); end
    checks++; if (out_ready !== 1'b0 || host_out_avail_tgl !== 1'b0 || host_out_data !== 16'h0) begin errors++; $display("[TB] FAIL mid_out_reset got %0h/%0h/%0h want 0/0/0", out_ready, host_out_avail_tgl, host_out_data); end
    checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin errors++; $display("[TB] FAIL mid_counts got %0d/%0d want 0/0", in_count, out_count); end
    out_valid = 1'b0;
    in_ready  = 1'b1;
    reset     = 1'b0;
    tick();
    tick();
    checks++; if (in_valid !== 1'b0 || in_count !== 4'd0 || out_count !== 4'd0 || out_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release got v %0h ic %0d oc %0d r %0h want 0/0/0/1", in_valid, in_count, out_count, out_ready); end
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] want_count;
    in_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      host_in_data    = 32'h5000_0000 + i;
      host_in_req_tgl = ~host_in_req_tgl;
      tick();
      tick();
      want_count = CNT_W'(i);
      checks++; if (in_count !== want_count || host_in_ack_tgl !== host_in_req_tgl) begin errors++; $display("[TB] FAIL wrap beat %0d got cnt %0d ack %0h want %0d/%0h", i, in_count, host_in_ack_tgl, want_count, host_in_req_tgl); end
    end
    checks++; if (in_count !== 4'd1 || host_in_ack_tgl !== 1'b1) begin errors++; $display("[TB] FAIL wrap_final got %0d/%0h want 1/1", in_count, host_in_ack_tgl); end
  endtask

  initial begin
    test_reset();
    test_single_in();
    test_in_backpressure();
    test_out_hold();
    test_simultaneous();
    test_reset_mid();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
